// File: rtl/cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-adapter signals seen by the arbiter.
interface cache_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  // Arbiter side.
  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );

  // Caches plus memory adapter side.
  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// Two-client cacheline arbiter: I-cache fills and D-cache fills/write-backs
// share one cacheline adapter, with alternating priority on conflicts.
//
// state   | meaning
// IDLE    | waiting for a request; grants and captures the transaction
// SERVE_I | I-cache fill in flight, waiting for mem_resp
// SERVE_D | D-cache fill or write-back in flight, waiting for mem_resp
// DONE    | one-cycle gap after completion, requests not sampled
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  cache_arbiter_if.slave   bus
);

  localparam int              OFF_W     = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;   // 1 when the last grant went to D
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                i_resp_c, d_resp_c;

  logic i_req, d_req, serving;

  assign i_req   = bus.i_read;
  assign d_req   = bus.d_read | bus.d_write;
  assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

  // State and captured-transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Grant decision, capture and completion handling.
  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    i_resp_c = 1'b0;
    d_resp_c = 1'b0;
    case (state_q)
      IDLE: begin
        // On a conflict the I side wins only if D had the previous grant.
        if (i_req && (!d_req || last_d_q)) begin
          state_d  = SERVE_I;
          last_d_d = 1'b0;
          addr_d   = bus.i_address & LINE_MASK;
          wr_d     = 1'b0;
          wdata_d  = '0;
        end else if (d_req) begin
          state_d  = SERVE_D;
          last_d_d = 1'b1;
          addr_d   = bus.d_address & LINE_MASK;
          wr_d     = bus.d_write;           // write-back beats a fill
          wdata_d  = bus.d_wdata;
        end
      end
      SERVE_I: begin
        if (bus.mem_resp) begin
          i_resp_c = 1'b1;
          state_d  = DONE;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp) begin
          d_resp_c = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_read    = serving & ~wr_q;
  assign bus.mem_write   = serving & wr_q;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.i_rdata     = bus.mem_rdata;
  assign bus.d_rdata     = bus.mem_rdata;
  assign bus.i_resp      = i_resp_c;
  assign bus.d_resp      = d_resp_c;

endmodule

// File: tb/tb_cache_arbiter.sv
// Randomized bench for cache_arbiter with a transaction-level reference model.
module tb_cache_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] MASK = 32'hFFFF_FFE0;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   last_was_d;   // model: side that received the most recent grant

  cache_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [LINE_W-1:0] got,
                           input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Services every pending request until none remain. first_lat is the
  // expected number of negedges from the call to the first memory command;
  // lat_fixed < 0 selects a random memory latency.
  task automatic serve_all(input int first_lat, input int lat_fixed, input bit scramble);
    bit                win_d, exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata, rdata;
    int                n, lat, exp_gap;
    exp_gap = first_lat;
    for (int t = 0; t < 4 && (bus.i_read || bus.d_read || bus.d_write); t++) begin
      if (bus.i_read && (bus.d_read || bus.d_write)) win_d = !last_was_d;
      else win_d = !bus.i_read;
      last_was_d = win_d;
      exp_addr  = (win_d ? bus.d_address : bus.i_address) & MASK;
      exp_wr    = win_d && bus.d_write;
      exp_wdata = bus.d_wdata;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(bus.mem_read || bus.mem_write) && n < 12);
      if (!(bus.mem_read || bus.mem_write)) begin
        check_val("grant_timeout", 0, 1);
        bus.i_read = 0; bus.d_read = 0; bus.d_write = 0;
        return;
      end
      check_val("grant_latency", n, exp_gap);
      exp_gap = 2;
      lat = (lat_fixed < 0) ? $urandom_range(0, 4) : lat_fixed;
      for (int k = 0; k <= lat; k++) begin
        if (k > 0) @(negedge clk);
        check_val("mem_read", bus.mem_read, !exp_wr);
        check_val("mem_write", bus.mem_write, exp_wr);
        check_val("mem_address", bus.mem_address, exp_addr);
        if (exp_wr) check_val("mem_wdata", bus.mem_wdata, exp_wdata);
        check_val("early_resp", {bus.i_resp, bus.d_resp}, 2'b00);
        if (scramble && $urandom_range(0, 1) == 1) begin
          if (win_d) begin
            bus.d_address = $urandom;
            if ($urandom_range(0, 1) == 1) begin bus.d_read = 0; bus.d_write = 0; end
          end else begin
            bus.i_address = $urandom;
            if ($urandom_range(0, 1) == 1) bus.i_read = 0;
          end
        end
      end
      rdata = rand_line();
      bus.mem_rdata = rdata;
      bus.mem_resp  = 1'b1;
      #1;
      check_val("i_resp", bus.i_resp, !win_d);
      check_val("d_resp", bus.d_resp, win_d);
      check_val(win_d ? "d_rdata" : "i_rdata", win_d ? bus.d_rdata : bus.i_rdata, rdata);
      @(negedge clk);
      bus.mem_resp = 1'b0;
      if (win_d) begin bus.d_read = 0; bus.d_write = 0; end
      else bus.i_read = 0;
      #1;
      check_val("done_idle_mem", {bus.mem_read, bus.mem_write}, 2'b00);
      check_val("done_no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_read = 0; bus.i_address = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_address = '0; bus.d_wdata = '0;
    bus.mem_resp = 0; bus.mem_rdata = rand_line();
    last_was_d = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_mem_read", bus.mem_read, 0);
    check_val("rst_mem_write", bus.mem_write, 0);
    check_val("rst_mem_address", bus.mem_address, 0);
    check_val("rst_mem_wdata", bus.mem_wdata, 0);
    check_val("rst_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    check_val("rst_rdata_pass", bus.i_rdata, bus.mem_rdata);
    rst_n = 1'b1;

    // Simultaneous I and D fills right after reset: D first, then I.
    @(negedge clk);
    bus.i_read = 1; bus.i_address = 32'h0000_1234;
    bus.d_read = 1; bus.d_address = 32'h0000_4321;
    serve_all(1, -1, 0);

    // Single I fill, unaligned address, memory latency 4.
    @(negedge clk);
    bus.i_read = 1; bus.i_address = 32'h0000_0064;
    serve_all(1, 4, 0);

    // D write-back with a recognisable data pattern.
    @(negedge clk);
    bus.d_write = 1; bus.d_address = 32'h0000_0100;
    bus.d_wdata = {32{8'hA5}};
    serve_all(1, 3, 0);

    // Spurious mem_resp while idle.
    @(negedge clk);
    bus.mem_resp = 1'b1;
    #1;
    check_val("spurious_resp", {bus.i_resp, bus.d_resp}, 2'b00);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    check_val("spurious_mem", {bus.mem_read, bus.mem_write}, 2'b00);
    bus.d_read = 1; bus.d_address = 32'h0000_0200;
    serve_all(1, 1, 1);

    // Reset in the middle of an I fill.
    @(negedge clk);
    bus.i_read = 1; bus.i_address = 32'h0000_0A40;
    @(negedge clk);
    check_val("pre_rst_mem_read", bus.mem_read, 1);
    #2 rst_n = 1'b0;
    bus.mem_resp = 1'b1;
    #1;
    check_val("async_rst_mem_read", bus.mem_read, 0);
    check_val("rst_no_i_resp", bus.i_resp, 0);
    @(negedge clk);
    bus.mem_resp = 1'b0;
    rst_n = 1'b1;
    last_was_d = 1'b0;
    serve_all(1, -1, 0);

    // Random mixes of requests, with mid-flight request changes.
    for (int it = 0; it < 40; it++) begin
      @(negedge clk);
      bus.i_read    = $urandom_range(0, 1);
      bus.d_read    = $urandom_range(0, 1);
      bus.d_write   = $urandom_range(0, 1);
      if (!bus.i_read && !bus.d_read && !bus.d_write) bus.i_read = 1;
      bus.i_address = $urandom;
      bus.d_address = $urandom;
      bus.d_wdata   = rand_line();
      serve_all(1, -1, (it % 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
